// File: rtl/bkgnd_pkg.sv
// Shared types and sizes for the background scanner and its image ROM.
package bkgnd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int ADDR_W     = 15;
  localparam int COLOUR_W   = 3;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 120;

  // Built-in background image: colour is the pixel address modulo 2**COLOUR_W.
  function automatic logic [COLOUR_W-1:0] rom_pixel(input logic [ADDR_W-1:0] a);
    return COLOUR_W'(a);
  endfunction

endpackage

// File: rtl/bkgnd_rom.sv
// Background image memory, DEPTH x COLOUR_W, synchronous read with one cycle of latency.
// Output holds its last word while en is low so a stalled pixel stays intact.
module bkgnd_rom
  import bkgnd_pkg::*;
#(
  parameter int DEPTH = DEF_WIDTH * DEF_HEIGHT
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [COLOUR_W-1:0] dat
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dat <= '0;
    end else if (en) begin
      dat <= (int'(addr) < DEPTH) ? rom_pixel(addr) : '0;
    end
  end

endmodule

// File: rtl/bkgnd_scanner.sv
// Sweeps a full WIDTH x HEIGHT background frame out of bkgnd_rom, one pixel per cycle, stallable by hold.
// Define BKGND_BORDER_EN to paint the frame edge with BORDER_COLOUR instead of ROM data.
module bkgnd_scanner
  import bkgnd_pkg::*;
#(
  parameter int                  WIDTH         = DEF_WIDTH,
  parameter int                  HEIGHT        = DEF_HEIGHT,
  parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                hold,
  output logic [X_W-1:0]      xPosition,
  output logic [Y_W-1:0]      yPosition,
  output logic [COLOUR_W-1:0] colourOut,
  output logic                plot,
  output logic                busy,
  output logic                done
);

`ifdef BKGND_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  state_t                state;
  logic [X_W-1:0]        x_cnt;
  logic [Y_W-1:0]        y_cnt;
  logic [ADDR_W-1:0]     addr;
  logic [X_W-1:0]        x_pipe;
  logic [Y_W-1:0]        y_pipe;
  logic                  pipe_vld;
  logic [COLOUR_W-1:0]   rom_dat;
  logic                  issue;
  logic                  last_x;
  logic                  last_y;
  logic                  on_border;
  logic [COLOUR_W-1:0]   pix_colour;

  always_comb begin
    issue      = (state == S_SCAN) && !hold;
    last_x     = (x_cnt == X_W'(WIDTH - 1));
    last_y     = (y_cnt == Y_W'(HEIGHT - 1));
    on_border  = (x_pipe == '0) || (x_pipe == X_W'(WIDTH - 1)) ||
                 (y_pipe == '0) || (y_pipe == Y_W'(HEIGHT - 1));
    pix_colour = (BORDER_ON && on_border) ? BORDER_COLOUR : rom_dat;
  end

  bkgnd_rom #(
    .DEPTH (WIDTH * HEIGHT)
  ) u_rom (
    .clock  (clock),
    .resetn (resetn),
    .en     (issue),
    .addr   (addr),
    .dat    (rom_dat)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      addr      <= '0;
      x_pipe    <= '0;
      y_pipe    <= '0;
      pipe_vld  <= 1'b0;
      xPosition <= '0;
      yPosition <= '0;
      colourOut <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Coordinates travel alongside the ROM read so they line up with rom_dat.
      if (!hold) begin
        pipe_vld <= issue;
        if (issue) begin
          x_pipe <= x_cnt;
          y_pipe <= y_cnt;
        end
      end

      if (hold) begin
        plot <= 1'b0;
      end else begin
        plot <= pipe_vld;
        if (pipe_vld) begin
          xPosition <= x_pipe;
          yPosition <= y_pipe;
          colourOut <= pix_colour;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SCAN;
            x_cnt <= '0;
            y_cnt <= '0;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (!hold) begin
            addr <= addr + 1'b1;
            if (last_x) begin
              x_cnt <= '0;
              if (last_y) begin
                y_cnt <= '0;
                addr  <= '0;
                state <= S_FLUSH;
              end else begin
                y_cnt <= y_cnt + 1'b1;
              end
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
        // Wait until the final pixel has actually left the output stage.
        S_FLUSH: begin
          if (!pipe_vld) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bkgnd_scanner.sv
// Directed bench for bkgnd_scanner; expected pixels come from a local model of the address-mod-8 image.
module tb_bkgnd_scanner;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       start  = 1'b0;
  logic       hold   = 1'b0;
  logic [7:0] xPosition;
  logic [6:0] yPosition;
  logic [2:0] colourOut;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int exp_x;
  int exp_y;

  always #5 clock = ~clock;

  bkgnd_scanner #(
    .WIDTH         (160),
    .HEIGHT        (120),
    .BORDER_COLOUR (3'b010)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .hold      (hold),
    .xPosition (xPosition),
    .yPosition (yPosition),
    .colourOut (colourOut),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [2:0] model_colour(input int x, input int y);
    int         a;
    logic [2:0] c;
    a = y * 160 + x;
    c = 3'(a);
`ifdef BKGND_BORDER_EN
    if (x == 0 || x == 159 || y == 0 || y == 119) c = 3'b010;
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
    end
    checks++;
    if (xPosition !== 8'd0 || yPosition !== 7'd0 || colourOut !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d c=%0d, want 0 0 0", xPosition, yPosition, colourOut);
    end
    resetn = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b plot=%b, want 0 0", busy, plot);
    end
  endtask

  task automatic test_full_sweep();
    int cyc;
    int nplots   = 0;
    int first_c  = -1;
    int last_c   = -1;
    int done_c   = -1;
    int ndone    = 0;
    exp_x = 0;
    exp_y = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: busy=%b, want 1", busy);
    end
    while (cyc < 19210) begin
      start = (cyc == 99);
      tick();
      cyc++;
      if (plot) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        nplots++;
        checks++;
        if (xPosition !== 8'(exp_x) || yPosition !== 7'(exp_y) || colourOut !== model_colour(exp_x, exp_y)) begin
          errors++;
          $display("FAIL pixel_seq: got (%0d,%0d) c%0d, want (%0d,%0d) c%0d at cycle %0d",
                   xPosition, yPosition, colourOut, exp_x, exp_y, model_colour(exp_x, exp_y), cyc);
        end
        if (exp_x == 5 && exp_y == 1) begin
          checks++;
          if (colourOut !== 3'd5) begin
            errors++;
            $display("FAIL pixel_5_1: colour=%0d, want 5", colourOut);
          end
        end
        if (exp_x == 159) begin exp_x = 0; exp_y++; end else exp_x++;
      end
      if (done) begin
        ndone++;
        done_c = cyc;
        checks++;
        if (plot !== 1'b0) begin
          errors++;
          $display("FAIL done_plot: plot=%b during done, want 0", plot);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first_c !== 2) begin
      errors++;
      $display("FAIL first_plot_cycle: got %0d, want 2", first_c);
    end
    checks++;
    if (last_c !== 19201) begin
      errors++;
      $display("FAIL last_plot_cycle: got %0d, want 19201", last_c);
    end
    checks++;
    if (done_c !== 19202 || ndone !== 1) begin
      errors++;
      $display("FAIL done_pulse: cycle %0d count %0d, want cycle 19202 count 1", done_c, ndone);
    end
    checks++;
    if (nplots !== 19200) begin
      errors++;
      $display("FAIL plot_count: got %0d, want 19200", nplots);
    end
    checks++;
    if (busy !== 1'b0 || xPosition !== 8'd159 || yPosition !== 7'd119) begin
      errors++;
      $display("FAIL end_state: busy=%b x=%0d y=%0d, want 0 159 119", busy, xPosition, yPosition);
    end
  endtask

  task automatic test_hold_and_reset();
    int cyc;
    bit hold_now;
    bit held = 1'b0;
    exp_x = 0;
    exp_y = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 5000) begin
      tick();
      cyc++;
      hold_now = 1'b0;
      if (plot) begin
        checks++;
        if (xPosition !== 8'(exp_x) || yPosition !== 7'(exp_y) || colourOut !== model_colour(exp_x, exp_y)) begin
          errors++;
          $display("FAIL hold_pixel_seq: got (%0d,%0d) c%0d, want (%0d,%0d) at cycle %0d",
                   xPosition, yPosition, colourOut, exp_x, exp_y, cyc);
        end
        hold_now = !held && exp_x == 40 && exp_y == 3;
        if (exp_x == 159) begin exp_x = 0; exp_y++; end else exp_x++;
      end
      if (hold_now) begin
        held = 1'b1;
        hold = 1'b1;
        repeat (10) begin
          tick();
          cyc++;
          checks++;
          if (plot !== 1'b0 || xPosition !== 8'd40 || yPosition !== 7'd3 || colourOut !== model_colour(40, 3)) begin
            errors++;
            $display("FAIL hold_freeze: plot=%b (%0d,%0d) c%0d, want 0 (40,3) c%0d",
                     plot, xPosition, yPosition, colourOut, model_colour(40, 3));
          end
        end
        hold = 1'b0;
        tick();
        cyc++;
        checks++;
        if (plot !== 1'b1 || xPosition !== 8'd41 || yPosition !== 7'd3 || colourOut !== model_colour(41, 3)) begin
          errors++;
          $display("FAIL hold_resume: plot=%b (%0d,%0d) c%0d, want 1 (41,3) c%0d",
                   plot, xPosition, yPosition, colourOut, model_colour(41, 3));
        end
        exp_x = 42;
      end
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL hold_reached: pixel (40,3) never plotted, got 0 want 1");
    end
    resetn = 1'b0;
    #2;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        xPosition !== 8'd0 || yPosition !== 7'd0 || colourOut !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, want all 0",
               plot, busy, done, xPosition, yPosition, colourOut);
    end
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0 || xPosition !== 8'd0) begin
      errors++;
      $display("FAIL no_resume: busy=%b plot=%b x=%0d, want 0 0 0", busy, plot, xPosition);
    end
  endtask

  task automatic test_start_held();
    int cyc;
    int nplots = 0;
    int done_c = -1;
    exp_x = 0;
    exp_y = 0;
    start = 1'b1;
    tick();
    cyc = 0;
    while (cyc < 19300 && done_c < 0) begin
      tick();
      cyc++;
      if (plot) begin
        nplots++;
        checks++;
        if (xPosition !== 8'(exp_x) || yPosition !== 7'(exp_y) || colourOut !== model_colour(exp_x, exp_y)) begin
          errors++;
          $display("FAIL held_pixel_seq: got (%0d,%0d) c%0d, want (%0d,%0d) at cycle %0d",
                   xPosition, yPosition, colourOut, exp_x, exp_y, cyc);
        end
        if (exp_x == 159) begin exp_x = 0; exp_y++; end else exp_x++;
      end
      if (done) done_c = cyc;
    end
    checks++;
    if (done_c !== 19202 || nplots !== 19200) begin
      errors++;
      $display("FAIL held_sweep: done at %0d with %0d plots, want 19202 with 19200", done_c, nplots);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_between: busy=%b done=%b, want 0 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_idle: busy=%b, want 1", busy);
    end
    start = 1'b0;
    repeat (2) tick();
    checks++;
    if (plot !== 1'b1 || xPosition !== 8'd0 || yPosition !== 7'd0 || colourOut !== model_colour(0, 0)) begin
      errors++;
      $display("FAIL restart_first_pixel: plot=%b (%0d,%0d) c%0d, want 1 (0,0) c%0d",
               plot, xPosition, yPosition, colourOut, model_colour(0, 0));
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_hold_and_reset();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
